seg_scan_capture: RTL and testbench
===================================

// Module: seg_scan_capture
// PURPOSE
//  Receive end of the multiplexed 6-digit FND bus (o_seg/o_seg_dp/o_seg_enb) driven by led_disp.
//  Samples each digit dwell, inverts the fnd_dec segment code back to BCD, assembles a full frame
//  and reconstructs binary min/sec (0~59). Used as a display monitor/self-check beside top_hms_clock.
// PARAMETERS
//  SETTLE_CYC   16         clk cycles i_seg_enb must be stable and legal before one sample is taken
//  TIMEOUT_CYC  32'd100000 clk cycles without a capture before o_stall asserts
// PORTS
//  clk          in   1   system clock (50MHz)
//  rst_n        in   1   reset, asynchronous, active-low
//  i_seg        in   7   segment bus {a,b,c,d,e,f,g}, active-high
//  i_seg_dp     in   1   decimal point of the enabled digit
//  i_seg_enb    in   6   common enable, active-low one-hot; bit k = digit k (0 = sec right)
//  o_digits     out  24  published BCD digits, digit k at [4k+3:4k]
//  o_dp         out  6   published dp per digit
//  o_seg_err    out  6   published per-digit illegal segment pattern flag
//  o_sec        out  6   binary seconds = digit1*10 + digit0
//  o_min        out  6   binary minutes = digit3*10 + digit2
//  o_frame_vld  out  1   1-cycle pulse: new frame published
//  o_time_err   out  1   last frame's min/sec digits not a legal 0~59 value
//  o_stall      out  1   no capture for TIMEOUT_CYC cycles
// BEHAVIOUR
//  - Reset: all outputs 0, shadow regs/capture mask/counters 0. Reset mid-frame discards partial frame.
//  - All 14 input bits pass a 2-flop synchronizer; all logic below uses synced values.
//  - Legal enb: exactly one bit 0. Illegal (all 1s / multiple 0s) = idle: settle cnt held 0, no capture.
//  - Settle cnt: +1 each cycle enb equal to previous cycle and legal; cleared on any change.
//    Capture when cnt == SETTLE_CYC-1, once per dwell (sampled flag cleared on enb change).
//    Change at exactly cnt == SETTLE_CYC-1 -> no capture.
//  - Capture writes decoded value, dp, err into shadow slot k; sets mask[k]. Re-capture of a slot
//    already in mask overwrites shadow, mask unchanged (out-of-order scan tolerated).
//  - Decode: 7E=0 30=1 6D=2 79=3 33=4 5B=5 5F=6 70=7 7F=8 73=9 (err 0); 00=blank -> 4'hF, err 0;
//    any other pattern -> 4'hE, err 1.
//  - Frame: cycle after mask becomes 6'b111111: o_digits/o_dp/o_seg_err load from shadow,
//    o_frame_vld=1 for one cycle, mask cleared. Outputs hold between frames.
//  - Time: computed from shadow in the publish cycle. Legal iff digit0,digit2 in 0..9 and
//    digit1,digit3 in 0..5. Legal -> o_sec/o_min update, o_time_err=0. Else o_sec/o_min hold,
//    o_time_err=1. o_time_err updates only on publish. Digits 4,5 not range-checked.
//  - Arithmetic: d*10 as (d<<3)+(d<<1), 6-bit result; max legal 59, no overflow.
//  - Stall: idle cnt +1 per cycle, cleared on capture; at TIMEOUT_CYC o_stall=1, mask cleared,
//    cnt saturates. o_stall clears the cycle after the next capture.
//  - Latency: input change -> capture = 2 sync + SETTLE_CYC cycles; last capture -> publish = 1.
// TESTING
//  1 led_disp-style scan (5000 clk/digit), 12:34, digits 5,4 blank -> o_frame_vld pulse,
//    o_digits=24'hFF1234, o_min=12, o_sec=34, o_seg_err=0, o_time_err=0.
//  2 digit3 enb held 10 cycles then switched -> no capture for digit3, no frame until next dwell.
//  3 digit2 pattern 7'h01 -> o_seg_err[2]=1, o_digits[11:8]=4'hE, o_time_err=1, o_min/o_sec hold.
//  4 digit1 pattern 5F (6) -> o_time_err=1, o_sec unchanged; next frame 59:59 then 00:00 -> updates.
//  5 enb 6'b111111 held TIMEOUT_CYC -> o_stall=1; resume scan -> o_stall=0 after first capture.
//  6 rst_n low after 3 captures -> all outputs 0; frame_vld only after 6 fresh captures.

Source files
------------

// File: rtl/seg_scan_capture_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seg_scan_capture_if
//  Description : Multiplexed 6-digit FND bus (segments, dp, active-low
//                digit enables). The display driver is the master; the
//                scan-capture monitor is the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_capture_if;
    logic [6:0] seg;      // {a,b,c,d,e,f,g}, active-high
    logic       seg_dp;   // decimal point of the enabled digit
    logic [5:0] seg_enb;  // active-low one-hot digit enable

    modport master (output seg, output seg_dp, output seg_enb);
    modport slave  (input  seg, input  seg_dp, input  seg_enb);
endinterface
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seg_scan_capture
//  Description : Receive side of the multiplexed FND bus. Samples each digit
//                dwell once it has settled, decodes the segment code back to
//                BCD, assembles a 6-digit frame and rebuilds binary min/sec.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_capture #(
    parameter int          SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 32'd100000
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_capture_if.slave   fnd,
    output logic [23:0]         o_digits,
    output logic [5:0]          o_dp,
    output logic [5:0]          o_seg_err,
    output logic [5:0]          o_sec,
    output logic [5:0]          o_min,
    output logic                o_frame_vld,
    output logic                o_time_err,
    output logic                o_stall
);

    localparam int                   c_CNT_W       = $clog2(SETTLE_CYC) + 1;
    localparam logic [c_CNT_W-1:0]   c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [5:0]           c_ALL_DIGITS  = 6'h3F;

    // d*10 built from shifts; callers only pass digits 0..5 so 6 bits suffice
    function automatic logic [5:0] times10(input logic [3:0] d);
        return ({2'b00, d} << 3) + ({2'b00, d} << 1);
    endfunction

    logic [13:0]         r_sync1, r_sync2;
    logic [5:0]          r_enb_prev;
    logic [c_CNT_W-1:0]  r_settle;
    logic                r_sampled;
    logic [23:0]         r_sh_dig;
    logic [5:0]          r_sh_dp, r_sh_err, r_mask;
    logic [31:0]         r_idle;

    logic [5:0]          w_enb, w_enb_n;
    logic [6:0]          w_seg;
    logic                w_dp, w_legal, w_stable, w_capture, w_publish, w_timeout;
    logic [3:0]          w_dec;
    logic                w_dec_err;
    logic                w_time_ok;
    logic [5:0]          w_sec, w_min;

    // Two-flop synchronizer for the whole asynchronous bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {fnd.seg_enb, fnd.seg_dp, fnd.seg};
            r_sync2 <= r_sync1;
        end
    end

    assign w_enb   = r_sync2[13:8];
    assign w_dp    = r_sync2[7];
    assign w_seg   = r_sync2[6:0];
    assign w_enb_n = ~w_enb;
    // Exactly one digit enabled; all-off or several-on is treated as idle
    assign w_legal   = (w_enb_n != 6'd0) && ((w_enb_n & (w_enb_n - 6'd1)) == 6'd0);
    assign w_stable  = w_legal && (w_enb == r_enb_prev);
    // A change on the very cycle the count would fire suppresses the sample
    assign w_capture = w_stable && (r_settle == c_SETTLE_LAST) && !r_sampled;
    assign w_publish = (r_mask == c_ALL_DIGITS);
    assign w_timeout = (r_idle == TIMEOUT_CYC);

    // Inverse of the segment encoder; blank maps to F, garbage to E
    always_comb begin
        w_dec_err = 1'b0;
        case (w_seg)
            7'h7E:   w_dec = 4'd0;
            7'h30:   w_dec = 4'd1;
            7'h6D:   w_dec = 4'd2;
            7'h79:   w_dec = 4'd3;
            7'h33:   w_dec = 4'd4;
            7'h5B:   w_dec = 4'd5;
            7'h5F:   w_dec = 4'd6;
            7'h70:   w_dec = 4'd7;
            7'h7F:   w_dec = 4'd8;
            7'h73:   w_dec = 4'd9;
            7'h00:   w_dec = 4'hF;
            default: begin
                w_dec     = 4'hE;
                w_dec_err = 1'b1;
            end
        endcase
    end

    // Settle counter: one sample per stable dwell, re-armed on any enable change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enb_prev <= '0;
            r_settle   <= '0;
            r_sampled  <= 1'b0;
        end else begin
            r_enb_prev <= w_enb;
            if (!w_stable) begin
                r_settle  <= '0;
                r_sampled <= 1'b0;
            end else begin
                if (r_settle != c_SETTLE_LAST)
                    r_settle <= r_settle + c_CNT_W'(1);
                if (w_capture)
                    r_sampled <= 1'b1;
            end
        end
    end

    // Shadow slots; a repeated digit simply overwrites its slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_dig <= '0;
            r_sh_dp  <= '0;
            r_sh_err <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < 6; k++) begin
                if (w_enb_n[k]) begin
                    r_sh_dig[4*k +: 4] <= w_dec;
                    r_sh_dp[k]         <= w_dp;
                    r_sh_err[k]        <= w_dec_err;
                end
            end
        end
    end

    // Capture mask: cleared on publish and whenever the bus has gone stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mask <= '0;
        else if (w_publish)
            r_mask <= '0;
        else if (w_capture)
            r_mask <= r_mask | w_enb_n;
        else if (w_timeout)
            r_mask <= '0;
    end

    assign w_time_ok = (r_sh_dig[3:0]   <= 4'd9) && (r_sh_dig[11:8]  <= 4'd9) &&
                       (r_sh_dig[7:4]   <= 4'd5) && (r_sh_dig[15:12] <= 4'd5);
    assign w_sec     = times10(r_sh_dig[7:4])   + {2'b00, r_sh_dig[3:0]};
    assign w_min     = times10(r_sh_dig[15:12]) + {2'b00, r_sh_dig[11:8]};

    // Frame publish; min/sec only move when the frame holds a legal time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_digits    <= '0;
            o_dp        <= '0;
            o_seg_err   <= '0;
            o_sec       <= '0;
            o_min       <= '0;
            o_frame_vld <= 1'b0;
            o_time_err  <= 1'b0;
        end else begin
            o_frame_vld <= w_publish;
            if (w_publish) begin
                o_digits  <= r_sh_dig;
                o_dp      <= r_sh_dp;
                o_seg_err <= r_sh_err;
                if (w_time_ok) begin
                    o_sec      <= w_sec;
                    o_min      <= w_min;
                    o_time_err <= 1'b0;
                end else begin
                    o_time_err <= 1'b1;
                end
            end
        end
    end

    // Idle watchdog: saturates at the timeout and holds stall until a capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle  <= '0;
            o_stall <= 1'b0;
        end else if (w_capture) begin
            r_idle  <= '0;
            o_stall <= 1'b0;
        end else if (w_timeout) begin
            o_stall <= 1'b1;
        end else begin
            r_idle <= r_idle + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_capture
//  Description : Directed self-checking bench for seg_scan_capture. Drives
//                led_disp-style digit scans and checks published frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_capture;

    localparam int          SETTLE = 16;
    localparam int unsigned TMO    = 32'd1000;
    localparam int          DWELL  = 64;

    localparam logic [6:0] S0 = 7'h7E, S1 = 7'h30, S2 = 7'h6D, S3 = 7'h79, S4 = 7'h33;
    localparam logic [6:0] S5 = 7'h5B, S6 = 7'h5F, S7 = 7'h70, S8 = 7'h7F, S9 = 7'h73;
    localparam logic [6:0] SB = 7'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] o_digits;
    logic [5:0]  o_dp, o_seg_err, o_sec, o_min;
    logic        o_frame_vld, o_time_err, o_stall;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt = 0;
    int fc0;

    seg_scan_capture_if bus ();

    seg_scan_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fnd         (bus),
        .o_digits    (o_digits),
        .o_dp        (o_dp),
        .o_seg_err   (o_seg_err),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_frame_vld (o_frame_vld),
        .o_time_err  (o_time_err),
        .o_stall     (o_stall)
    );

    always #5 clk = ~clk;

    // Count publish pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (o_frame_vld) frame_cnt++;
    end

    task automatic scan_digit(input int k, input logic [6:0] seg, input logic dp, input int cyc);
        logic [5:0] one;
        one = 6'b000001;
        @(negedge clk);
        bus.seg_enb = ~(one << k);
        bus.seg     = seg;
        bus.seg_dp  = dp;
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic scan_range(input logic [41:0] segs, input logic [5:0] dps, input int first, input int last);
        for (int k = first; k <= last; k++)
            scan_digit(k, segs[7*k +: 7], dps[k], DWELL);
    endtask

    task automatic go_idle(input int cyc);
        @(negedge clk);
        bus.seg_enb = 6'h3F;
        bus.seg     = 7'h00;
        bus.seg_dp  = 1'b0;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.seg_enb = 6'h3F; bus.seg = 7'h00; bus.seg_dp = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({o_digits, o_dp, o_seg_err, o_sec, o_min, o_frame_vld, o_time_err, o_stall} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got digits=%h dp=%b err=%b sec=%0d min=%0d vld=%b terr=%b stall=%b, expected all 0",
                     o_digits, o_dp, o_seg_err, o_sec, o_min, o_frame_vld, o_time_err, o_stall);
        end
    endtask

    task automatic test_basic_frame();
        fc0 = frame_cnt;
        scan_range({SB, SB, S1, S2, S3, S4}, 6'b000100, 0, 5);
        n_checks++;
        if (frame_cnt - fc0 !== 1) begin n_fail++; $display("FAIL t1_frame_pulses: got %0d expected 1", frame_cnt - fc0); end
        n_checks++;
        if (o_digits !== 24'hFF1234) begin n_fail++; $display("FAIL t1_digits: got %h expected FF1234", o_digits); end
        n_checks++;
        if (o_min !== 6'd12 || o_sec !== 6'd34) begin n_fail++; $display("FAIL t1_time: got %0d:%0d expected 12:34", o_min, o_sec); end
        n_checks++;
        if (o_dp !== 6'b000100) begin n_fail++; $display("FAIL t1_dp: got %b expected 000100", o_dp); end
        n_checks++;
        if (o_seg_err !== 6'd0 || o_time_err !== 1'b0) begin n_fail++; $display("FAIL t1_errs: got seg_err=%b time_err=%b expected 0/0", o_seg_err, o_time_err); end
    endtask

    task automatic test_short_dwell();
        fc0 = frame_cnt;
        scan_range({SB, SB, S2, S3, S4, S5}, 6'b0, 0, 2);
        scan_digit(3, S2, 1'b0, 10);
        scan_range({SB, SB, S2, S3, S4, S5}, 6'b0, 4, 5);
        n_checks++;
        if (frame_cnt !== fc0) begin n_fail++; $display("FAIL t2_no_frame: got %0d pulses expected 0", frame_cnt - fc0); end
        n_checks++;
        if (o_digits !== 24'hFF1234) begin n_fail++; $display("FAIL t2_hold: got %h expected FF1234", o_digits); end
        scan_digit(3, S2, 1'b0, DWELL);
        n_checks++;
        if (frame_cnt - fc0 !== 1) begin n_fail++; $display("FAIL t2_late_frame: got %0d pulses expected 1", frame_cnt - fc0); end
        n_checks++;
        if (o_digits !== 24'hFF2345 || o_min !== 6'd23 || o_sec !== 6'd45) begin
            n_fail++; $display("FAIL t2_content: got %h %0d:%0d expected FF2345 23:45", o_digits, o_min, o_sec);
        end
    endtask

    task automatic test_seg_err();
        scan_range({SB, SB, S3, 7'h01, S1, S0}, 6'b0, 0, 5);
        n_checks++;
        if (o_digits !== 24'hFF3E10) begin n_fail++; $display("FAIL t3_digits: got %h expected FF3E10", o_digits); end
        n_checks++;
        if (o_seg_err !== 6'b000100) begin n_fail++; $display("FAIL t3_seg_err: got %b expected 000100", o_seg_err); end
        n_checks++;
        if (o_time_err !== 1'b1 || o_min !== 6'd23 || o_sec !== 6'd45) begin
            n_fail++; $display("FAIL t3_time_hold: got terr=%b %0d:%0d expected 1 23:45", o_time_err, o_min, o_sec);
        end
    endtask

    task automatic test_time_range();
        scan_range({SB, SB, S0, S7, S6, S9}, 6'b0, 0, 5);
        n_checks++;
        if (o_digits !== 24'hFF0769 || o_seg_err !== 6'd0) begin n_fail++; $display("FAIL t4_digits: got %h err=%b expected FF0769 000000", o_digits, o_seg_err); end
        n_checks++;
        if (o_time_err !== 1'b1 || o_sec !== 6'd45 || o_min !== 6'd23) begin
            n_fail++; $display("FAIL t4_sec_hold: got terr=%b %0d:%0d expected 1 23:45", o_time_err, o_min, o_sec);
        end
        scan_range({SB, SB, S5, S9, S5, S9}, 6'b0, 0, 5);
        n_checks++;
        if (o_time_err !== 1'b0 || o_min !== 6'd59 || o_sec !== 6'd59) begin
            n_fail++; $display("FAIL t4_5959: got terr=%b %0d:%0d expected 0 59:59", o_time_err, o_min, o_sec);
        end
        scan_range({SB, SB, S0, S0, S0, S0}, 6'b0, 0, 5);
        n_checks++;
        if (o_time_err !== 1'b0 || o_min !== 6'd0 || o_sec !== 6'd0 || o_digits !== 24'hFF0000) begin
            n_fail++; $display("FAIL t4_0000: got terr=%b %0d:%0d %h expected 0 0:0 FF0000", o_time_err, o_min, o_sec, o_digits);
        end
    endtask

    task automatic test_stall();
        fc0 = frame_cnt;
        scan_range({SB, SB, S4, S8, S8, S8}, 6'b0, 0, 2);
        go_idle(500);
        n_checks++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL t5_early_stall: got %b expected 0", o_stall); end
        go_idle(int'(TMO) - 400);
        n_checks++;
        if (o_stall !== 1'b1) begin n_fail++; $display("FAIL t5_stall: got %b expected 1", o_stall); end
        scan_range({SB, SB, S4, S5, S0, S1}, 6'b0, 3, 3);
        n_checks++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL t5_resume: got %b expected 0", o_stall); end
        scan_range({SB, SB, S4, S5, S0, S1}, 6'b0, 4, 5);
        n_checks++;
        if (frame_cnt !== fc0) begin n_fail++; $display("FAIL t5_mask_cleared: got %0d pulses expected 0", frame_cnt - fc0); end
        scan_range({SB, SB, S4, S5, S0, S1}, 6'b0, 0, 2);
        n_checks++;
        if (frame_cnt - fc0 !== 1 || o_digits !== 24'hFF4501 || o_min !== 6'd45 || o_sec !== 6'd1) begin
            n_fail++; $display("FAIL t5_frame: got %0d pulses %h %0d:%0d expected 1 FF4501 45:1", frame_cnt - fc0, o_digits, o_min, o_sec);
        end
    endtask

    task automatic test_reset_mid_frame();
        scan_range({SB, SB, S8, S8, S8, S8}, 6'b000111, 0, 2);
        @(negedge clk);
        bus.seg_enb = 6'h3F;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_digits, o_dp, o_seg_err, o_sec, o_min, o_frame_vld, o_time_err, o_stall} !== 53'd0) begin
            n_fail++;
            $display("FAIL t6_reset_outputs: got digits=%h dp=%b err=%b sec=%0d min=%0d terr=%b stall=%b, expected all 0",
                     o_digits, o_dp, o_seg_err, o_sec, o_min, o_time_err, o_stall);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        fc0 = frame_cnt;
        scan_range({SB, SB, S1, S0, S5, S9}, 6'b0, 3, 5);
        n_checks++;
        if (frame_cnt !== fc0 || o_digits !== 24'h0) begin
            n_fail++; $display("FAIL t6_partial_discarded: got %0d pulses digits=%h expected 0 000000", frame_cnt - fc0, o_digits);
        end
        scan_range({SB, SB, S1, S0, S5, S9}, 6'b0, 0, 2);
        n_checks++;
        if (frame_cnt - fc0 !== 1 || o_digits !== 24'hFF1059 || o_min !== 6'd10 || o_sec !== 6'd59 || o_dp !== 6'd0) begin
            n_fail++; $display("FAIL t6_fresh_frame: got %0d pulses %h %0d:%0d dp=%b expected 1 FF1059 10:59 000000",
                               frame_cnt - fc0, o_digits, o_min, o_sec, o_dp);
        end
    endtask

    initial begin
        bus.seg_enb = 6'h3F;
        bus.seg     = 7'h00;
        bus.seg_dp  = 1'b0;
        test_reset();
        test_basic_frame();
        test_short_dwell();
        test_seg_err();
        test_time_range();
        test_stall();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
